// File: rtl/uart_frame_packer.sv
// FIFO-to-UART framer: drains words from a show-behind FIFO and sends each burst as
// header, word count, payload bytes and an optional mod-256 payload checksum.
module uart_frame_packer #(
  parameter int         WORD_W      = 32,
  parameter int         LEVEL_W     = 10,
  parameter int         FRAME_WORDS = 16,
  parameter int         MSB_FIRST   = 1,
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         CKSUM_EN    = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [WORD_W-1:0]  FifoQ,
  input  logic               FifoEmpty,
  input  logic [LEVEL_W-1:0] FifoLevel,
  output logic               FifoRdReq,
  input  logic               Flush,
  input  logic               UartReady,
  output logic [7:0]         TxData,
  output logic               TxStart,
  output logic               Busy,
  output logic               FrameDone
);

  localparam int          BYTES_PER_WORD = WORD_W / 8;
  localparam logic [3:0]  LAST_BYTE      = 4'(BYTES_PER_WORD - 1);
  localparam logic [7:0]  FRAME_WORDS_B  = 8'(FRAME_WORDS);
  localparam logic [31:0] FRAME_WORDS_U  = 32'(FRAME_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LEN,
    FETCH,
    WAIT,
    LOAD,
    BYTE,
    CKS,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                guard_q, guard_d;
  logic [7:0]          nWords_q, nWords_d;
  logic [7:0]          wordCnt_q, wordCnt_d;
  logic [3:0]          byteCnt_q, byteCnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [7:0]          txData_q, txData_d;
  logic                txStart_q, txStart_d;

  logic [31:0]         levelWide;
  logic                fullFrame;
  logic [7:0]          flushWords;
  logic [7:0]          curByte;
  logic [WORD_W-1:0]   shiftNext;
  logic [7:0]          wordNext;
  logic                launchNow;

  assign levelWide  = 32'(FifoLevel);
  assign fullFrame  = (levelWide >= FRAME_WORDS_U);
  assign flushWords = (levelWide < FRAME_WORDS_U) ? levelWide[7:0] : FRAME_WORDS_B;
  assign curByte    = (MSB_FIRST != 0) ? shift_q[WORD_W-1 -: 8] : shift_q[7:0];
  assign shiftNext  = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
  assign wordNext   = wordCnt_q + 8'd1;
  // A launch may only happen outside the guard cycle that follows the previous one.
  assign launchNow  = !guard_q && UartReady;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      guard_q   <= 1'b0;
      nWords_q  <= '0;
      wordCnt_q <= '0;
      byteCnt_q <= '0;
      sum_q     <= '0;
      shift_q   <= '0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      nWords_q  <= nWords_d;
      wordCnt_q <= wordCnt_d;
      byteCnt_q <= byteCnt_d;
      sum_q     <= sum_d;
      shift_q   <= shift_d;
      txData_q  <= txData_d;
      txStart_q <= txStart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    nWords_d  = nWords_q;
    wordCnt_d = wordCnt_q;
    byteCnt_d = byteCnt_q;
    sum_d     = sum_q;
    shift_d   = shift_q;
    txData_d  = txData_q;
    txStart_d = 1'b0;

    case (state_q)
      IDLE: begin
        guard_d = 1'b0;
        // A full frame takes priority over a flush seen in the same cycle.
        if (fullFrame) begin
          nWords_d  = FRAME_WORDS_B;
          wordCnt_d = '0;
          state_d   = HDR;
        end else if (Flush && !FifoEmpty) begin
          nWords_d  = flushWords;
          wordCnt_d = '0;
          state_d   = HDR;
        end
      end

      HDR: begin
        if (launchNow) begin
          txData_d  = HDR_BYTE;
          txStart_d = 1'b1;
          guard_d   = 1'b1;
          sum_d     = '0;
        end else if (guard_q) begin
          guard_d = 1'b0;
          state_d = LEN;
        end
      end

      LEN: begin
        if (launchNow) begin
          txData_d  = nWords_q;
          txStart_d = 1'b1;
          guard_d   = 1'b1;
        end else if (guard_q) begin
          guard_d = 1'b0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (!FifoEmpty) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d   = FifoQ;
        byteCnt_d = '0;
        state_d   = BYTE;
      end

      BYTE: begin
        if (launchNow) begin
          txData_d  = curByte;
          txStart_d = 1'b1;
          guard_d   = 1'b1;
          sum_d     = sum_q + curByte;
          shift_d   = shiftNext;
        end else if (guard_q) begin
          guard_d = 1'b0;
          if (byteCnt_q == LAST_BYTE) begin
            wordCnt_d = wordNext;
            if (wordNext == nWords_q) begin
              state_d = (CKSUM_EN != 0) ? CKS : DONE;
            end else begin
              state_d = FETCH;
            end
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end

      CKS: begin
        if (launchNow) begin
          txData_d  = sum_q;
          txStart_d = 1'b1;
          guard_d   = 1'b1;
        end else if (guard_q) begin
          guard_d = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign FifoRdReq = (state_q == FETCH) && !FifoEmpty;
  assign TxData    = txData_q;
  assign TxStart   = txStart_q;
  assign Busy      = (state_q != IDLE);
  assign FrameDone = (state_q == DONE);

endmodule
